panel_datapath: RTL and testbench

//  Datapath slaved to the panel sequencer FSM for a 32x16, 1/8-scan HUB75 panel chain.
//  - Consumes the sequencer's strobes (sclk set/clr, row/col counter clr/enb, blank, lat).
//  - Returns colct_eq_max to the sequencer.
//  - Fetches two pixels per column (top/bottom half) from a double-buffered sync framebuffer.
//  - Applies PWM bit-plane compare and drives the panel pins: RGB1/RGB2, sclk, lat, oe_n, ABC.

---
 rtl/led_pkg.sv | 28 ++
 rtl/mod_counter.sv | 31 +++
 rtl/panel_datapath.sv | 157 +++++++++++++++
 tb/tb_panel_datapath.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and defaults for the HUB75 panel datapath.
// Pixel words arrive as {top R,G,B, bot R,G,B}, MSB first.
package led_pkg;

    localparam int COLS_PER_PANEL = 32;
    localparam int SCAN_ROWS      = 8;
    localparam int DEPTH          = 4;

    typedef struct packed {
        logic [DEPTH-1:0] r;
        logic [DEPTH-1:0] g;
        logic [DEPTH-1:0] b;
    } rgb_t;

    typedef struct packed {
        rgb_t top;
        rgb_t bot;
    } pix_pair_t;

    // A channel is lit on every plane strictly below its value.
    function automatic logic [2:0] pwm_bits(
        input rgb_t             px,
        input logic [DEPTH-1:0] plane
    );
        return {px.r > plane, px.g > plane, px.b > plane};
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with clear priority and a wrap strobe.
// wrap is combinational: high on the cycle an enable rolls MOD-1 to 0.
module mod_counter #(
    parameter int MOD = 8,
    parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         enb,
    output logic [W-1:0] count,
    output logic         at_max,
    output logic         wrap
);

    localparam logic [W-1:0] MAX = W'(MOD - 1);

    assign at_max = (count == MAX);
    assign wrap   = enb && !clr && at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (enb) begin
            count <= at_max ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/panel_datapath.sv
// HUB75 panel datapath: counters, framebuffer fetch, PWM compare
// and panel pin registers, slaved to the sequencer's strobes.
module panel_datapath #(
    parameter int  NUM_PANELS = 1,
    parameter int  DEPTH      = led_pkg::DEPTH,
    parameter int  SCAN_ROWS  = led_pkg::SCAN_ROWS,
    localparam int COLS       = led_pkg::COLS_PER_PANEL * NUM_PANELS,
    localparam int ROWW       = $clog2(SCAN_ROWS),
    localparam int COLW       = $clog2(COLS),
    localparam int AW         = 1 + ROWW + COLW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sclk_r_clr,
    input  logic               sclk_r_set,
    input  logic               rowct_clr,
    input  logic               rowct_enb,
    input  logic               colct_clr,
    input  logic               colct_enb,
    input  logic               blank,
    input  logic               lat,
    output logic               colct_eq_max,
    output logic [AW-1:0]      fb_addr,
    input  logic [6*DEPTH-1:0] fb_rdata,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               frame_start,
    output logic [2:0]         rgb1,
    output logic [2:0]         rgb2,
    output logic               sclk,
    output logic               lat_o,
    output logic               oe_n,
    output logic [ROWW-1:0]    row_addr
);

    import led_pkg::*;

    localparam int PLANES = 2**DEPTH - 1;
    localparam int PW     = (PLANES > 1) ? $clog2(PLANES) : 1;

    logic [COLW-1:0] col;
    logic [ROWW-1:0] row;
    logic [ROWW-1:0] shift_row;
    logic [PW-1:0]   plane;
    logic            col_max;
    logic            col_wrap;
    logic            row_max;
    logic            row_wrap;
    logic            plane_max;
    logic            plane_wrap;
    logic            buf_sel;
    logic            swap_armed;
    logic            do_swap;
    pix_pair_t       pix;
    logic            unused_ok;

    mod_counter #(.MOD(COLS)) u_col (
        .clk    (clk),
        .rst    (rst),
        .clr    (colct_clr),
        .enb    (colct_enb),
        .count  (col),
        .at_max (col_max),
        .wrap   (col_wrap)
    );

    mod_counter #(.MOD(SCAN_ROWS)) u_row (
        .clk    (clk),
        .rst    (rst),
        .clr    (rowct_clr),
        .enb    (rowct_enb),
        .count  (row),
        .at_max (row_max),
        .wrap   (row_wrap)
    );

    // Plane advances only when the last row pair of a plane is left.
    mod_counter #(.MOD(PLANES)) u_plane (
        .clk    (clk),
        .rst    (rst),
        .clr    (1'b0),
        .enb    (row_wrap),
        .count  (plane),
        .at_max (plane_max),
        .wrap   (plane_wrap)
    );

    assign colct_eq_max = col_max;
    assign unused_ok    = ^{col_wrap, row_max, plane_max};

    // One swap per request: re-armed only once swap_req drops.
    assign do_swap = plane_wrap && swap_req && swap_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_sel     <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            swap_armed  <= 1'b1;
        end else begin
            frame_start <= plane_wrap;
            swap_ack    <= do_swap;
            if (do_swap) begin
                buf_sel    <= ~buf_sel;
                swap_armed <= 1'b0;
            end else if (!swap_req) begin
                swap_armed <= 1'b1;
            end
        end
    end

    // ABC shows the row just shifted in, updated only on latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_row <= '0;
            row_addr  <= '0;
        end else begin
            if (rowct_enb && !rowct_clr) begin
                shift_row <= row;
            end
            if (lat) begin
                row_addr <= shift_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk  <= 1'b0;
            lat_o <= 1'b0;
            oe_n  <= 1'b1;
        end else begin
            if (sclk_r_clr) begin
                sclk <= 1'b0;
            end else if (sclk_r_set) begin
                sclk <= 1'b1;
            end
            lat_o <= lat;
            oe_n  <= blank;
        end
    end

    assign pix = pix_pair_t'(fb_rdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_addr <= '0;
            rgb1    <= 3'b000;
            rgb2    <= 3'b000;
        end else begin
            fb_addr <= {buf_sel, row, col};
            rgb1    <= pwm_bits(pix.top, plane);
            rgb2    <= pwm_bits(pix.bot, plane);
        end
    end

endmodule

// File: tb/tb_panel_datapath.sv
// Bench for panel_datapath: framebuffer model, cycle model, directed tests.
// The model tracks counters as integers and applies pipeline latencies.
module tb_panel_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk_r_clr = 1'b0;
    logic        sclk_r_set = 1'b0;
    logic        rowct_clr = 1'b0;
    logic        rowct_enb = 1'b0;
    logic        colct_clr = 1'b0;
    logic        colct_enb = 1'b0;
    logic        blank = 1'b1;
    logic        lat = 1'b0;
    logic        swap_req = 1'b0;
    logic        colct_eq_max;
    logic [8:0]  fb_addr;
    logic [23:0] fb_rdata;
    logic        swap_ack;
    logic        frame_start;
    logic [2:0]  rgb1;
    logic [2:0]  rgb2;
    logic        sclk;
    logic        lat_o;
    logic        oe_n;
    logic [2:0]  row_addr;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    logic [23:0] fbmem [512];

    panel_datapath dut (
        .clk          (clk),
        .rst          (rst),
        .sclk_r_clr   (sclk_r_clr),
        .sclk_r_set   (sclk_r_set),
        .rowct_clr    (rowct_clr),
        .rowct_enb    (rowct_enb),
        .colct_clr    (colct_clr),
        .colct_enb    (colct_enb),
        .blank        (blank),
        .lat          (lat),
        .colct_eq_max (colct_eq_max),
        .fb_addr      (fb_addr),
        .fb_rdata     (fb_rdata),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .frame_start  (frame_start),
        .rgb1         (rgb1),
        .rgb2         (rgb2),
        .sclk         (sclk),
        .lat_o        (lat_o),
        .oe_n         (oe_n),
        .row_addr     (row_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) fb_rdata <= fbmem[fb_addr];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    int          m_col, m_row, m_plane, m_buf, m_shift, m_rowaddr;
    logic        m_sclk, m_lat, m_oe, m_fs, m_ack, m_armed;
    logic [8:0]  m_fbaddr;
    logic [23:0] m_rdata;
    logic [2:0]  m_rgb1, m_rgb2;

    function automatic logic [2:0] lit(int r, int g, int b, int p);
        return {r > p, g > p, b > p};
    endfunction

    always @(posedge clk) begin
        logic [23:0] d;
        d = m_rdata;
        if (rst) begin
            m_rgb1 = 3'b000;
            m_rgb2 = 3'b000;
        end else begin
            m_rgb1 = lit(int'(d[23:20]), int'(d[19:16]), int'(d[15:12]), m_plane);
            m_rgb2 = lit(int'(d[11:8]), int'(d[7:4]), int'(d[3:0]), m_plane);
        end
        m_rdata = fbmem[m_fbaddr];
        if (rst) begin
            m_col = 0; m_row = 0; m_plane = 0; m_buf = 0;
            m_shift = 0; m_rowaddr = 0; m_fbaddr = '0;
            m_sclk = 0; m_lat = 0; m_oe = 1; m_fs = 0; m_ack = 0;
            m_armed = 1;
        end else begin
            m_fbaddr = {m_buf[0], 3'(m_row), 5'(m_col)};
            if (sclk_r_clr) m_sclk = 0;
            else if (sclk_r_set) m_sclk = 1;
            m_lat = lat;
            m_oe  = blank;
            if (lat) m_rowaddr = m_shift;
            m_fs  = 0;
            m_ack = 0;
            if (rowct_clr) begin
                m_row = 0;
            end else if (rowct_enb) begin
                m_shift = m_row;
                if (m_row == 7) begin
                    m_plane = (m_plane + 1) % 15;
                    if (m_plane == 0) begin
                        m_fs = 1;
                        if (swap_req && m_armed) begin
                            m_buf = 1 - m_buf;
                            m_ack = 1;
                        end
                    end
                end
                m_row = (m_row + 1) % 8;
            end
            if (m_ack) m_armed = 0;
            else if (!swap_req) m_armed = 1;
            if (colct_clr) m_col = 0;
            else if (colct_enb) m_col = (m_col + 1) % 32;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_sclk", 32'(sclk), 32'(m_sclk));
            chk("m_lat_o", 32'(lat_o), 32'(m_lat));
            chk("m_oe_n", 32'(oe_n), 32'(m_oe));
            chk("m_row_addr", 32'(row_addr), 32'(m_rowaddr));
            chk("m_eq_max", 32'(colct_eq_max), 32'(m_col == 31));
            chk("m_fb_addr", 32'(fb_addr), 32'(m_fbaddr));
            chk("m_frame_start", 32'(frame_start), 32'(m_fs));
            chk("m_swap_ack", 32'(swap_ack), 32'(m_ack));
            chk("m_rgb1", 32'(rgb1), 32'(m_rgb1));
            chk("m_rgb2", 32'(rgb2), 32'(m_rgb2));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int fs_n, ack_n, on_r1, on_g1, on_b1, on_r2, on_g2, on_b2;
        bit seen;
        for (int i = 0; i < 512; i++) fbmem[i] = 24'($urandom);
        repeat (4) tick();
        chk_on = 1;
        rst = 0;
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_oe_n", 32'(oe_n), 32'd1);
        chk("rst_rgb1", 32'(rgb1), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);

        // 1: reset mid-shift at col 17
        blank = 0;
        sclk_r_set = 1;
        colct_enb = 1;
        repeat (17) tick();
        sclk_r_set = 0;
        colct_enb = 0;
        rowct_enb = 1;
        repeat (3) tick();
        rowct_enb = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("t1_sclk", 32'(sclk), 32'd0);
        chk("t1_oe_n", 32'(oe_n), 32'd1);
        chk("t1_rgb1", 32'(rgb1), 32'd0);
        chk("t1_rgb2", 32'(rgb2), 32'd0);
        chk("t1_eq_max", 32'(colct_eq_max), 32'd0);
        chk("t1_fb_addr", 32'(fb_addr), 32'd0);
        tick();
        chk("t1_oe_n_after", 32'(oe_n), 32'd0);

        // 2: column sweep
        colct_enb = 1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk("t2_eq_max", 32'(colct_eq_max), 32'(i == 31));
        end
        colct_clr = 1;
        tick();
        colct_clr = 0;
        colct_enb = 0;
        chk("t2_clr_enb", 32'(colct_eq_max), 32'd0);
        tick();
        chk("t2_fb_col", 32'(fb_addr[4:0]), 32'd0);

        // 3: fetch latency at plane 6
        rowct_enb = 1;
        repeat (48) tick();
        rowct_enb = 0;
        colct_enb = 1;
        repeat (4) tick();
        colct_enb = 0;
        fbmem[{1'b0, 3'd0, 5'd4}] = 24'h000000;
        fbmem[{1'b0, 3'd0, 5'd5}] = 24'hF07000;
        repeat (4) tick();
        chk("t3_pre", 32'(rgb1), 32'd0);
        colct_enb = 1;
        tick();
        colct_enb = 0;
        for (int k = 1; k <= 4; k++) begin
            chk("t3_latency", 32'(rgb1), (k == 4) ? 32'd5 : 32'd0);
            if (k < 4) tick();
        end

        // 4: row / latch
        rowct_enb = 1;
        repeat (7) tick();
        rowct_enb = 0;
        lat = 1;
        tick();
        lat = 0;
        chk("t4_row_addr6", 32'(row_addr), 32'd6);
        rowct_enb = 1;
        tick();
        rowct_enb = 0;
        chk("t4_before_lat", 32'(row_addr), 32'd6);
        tick();
        chk("t4_fb_row", 32'(fb_addr[7:5]), 32'd0);
        repeat (3) tick();
        chk("t4_plane7", 32'(rgb1), 32'd4);
        lat = 1;
        tick();
        lat = 0;
        chk("t4_row_addr7", 32'(row_addr), 32'd7);

        // 5: plane wrap and swap
        swap_req = 1;
        rowct_enb = 1;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (frame_start) seen = 1;
        end
        rowct_enb = 0;
        chk("t5_wrap_seen", 32'(seen), 32'd1);
        chk("t5_ack", 32'(swap_ack), 32'd1);
        tick();
        chk("t5_buf1", 32'(fb_addr[8]), 32'd1);
        fs_n = 0;
        ack_n = 0;
        rowct_enb = 1;
        repeat (240) begin
            tick();
            fs_n += int'(frame_start);
            ack_n += int'(swap_ack);
        end
        rowct_enb = 0;
        swap_req = 0;
        chk("t5_held_fs", 32'(fs_n), 32'd2);
        chk("t5_held_ack", 32'(ack_n), 32'd0);
        tick();
        chk("t5_buf_kept", 32'(fb_addr[8]), 32'd1);
        swap_req = 1;
        repeat (5) tick();
        swap_req = 0;
        fs_n = 0;
        ack_n = 0;
        rowct_enb = 1;
        repeat (120) begin
            tick();
            fs_n += int'(frame_start);
            ack_n += int'(swap_ack);
        end
        rowct_enb = 0;
        chk("t5_drop_fs", 32'(fs_n), 32'd1);
        chk("t5_drop_ack", 32'(ack_n), 32'd0);
        swap_req = 1;
        rowct_enb = 1;
        ack_n = 0;
        repeat (120) begin
            tick();
            ack_n += int'(swap_ack);
        end
        rowct_enb = 0;
        swap_req = 0;
        chk("t5_second_ack", 32'(ack_n), 32'd1);
        tick();
        chk("t5_buf0", 32'(fb_addr[8]), 32'd0);

        // 6: brightness extremes over all planes
        for (int r = 0; r < 8; r++) begin
            fbmem[{1'b0, 3'(r), 5'd0}] = 24'h0F8F80;
            fbmem[{1'b1, 3'(r), 5'd0}] = 24'h0F8F80;
        end
        colct_clr = 1;
        tick();
        colct_clr = 0;
        on_r1 = 0; on_g1 = 0; on_b1 = 0;
        on_r2 = 0; on_g2 = 0; on_b2 = 0;
        for (int p = 0; p < 15; p++) begin
            repeat (4) tick();
            on_r1 += int'(rgb1[2]);
            on_g1 += int'(rgb1[1]);
            on_b1 += int'(rgb1[0]);
            on_r2 += int'(rgb2[2]);
            on_g2 += int'(rgb2[1]);
            on_b2 += int'(rgb2[0]);
            rowct_enb = 1;
            repeat (8) tick();
            rowct_enb = 0;
        end
        chk("t6_val0", 32'(on_r1), 32'd0);
        chk("t6_val15", 32'(on_g1), 32'd15);
        chk("t6_val8", 32'(on_b1), 32'd8);
        chk("t6_bot15", 32'(on_r2), 32'd15);
        chk("t6_bot8", 32'(on_g2), 32'd8);
        chk("t6_bot0", 32'(on_b2), 32'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
